// File: rtl/dmem_pkg.sv
// Shared types and access-size helpers for the data memory controller.
package dmem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } memop_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  // Access size in bytes from funct3[1:0]; the illegal 2'b11 encoding is faulted elsewhere.
  function automatic logic [2:0] size_of(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Byte mask over two consecutive words: bits 3:0 word A, bits 7:4 word A+1.
  function automatic logic [7:0] byte_en(input logic [1:0] off, input logic [2:0] size);
    logic [7:0] base;
    case (size)
      3'd1:    base = 8'h01;
      3'd2:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] size,
                                         input logic uns);
    case (size)
      3'd1:    return uns ? {24'b0, data[7:0]}  : {{24{data[7]}}, data[7:0]};
      3'd2:    return uns ? {16'b0, data[15:0]} : {{16{data[15]}}, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Single-port byte-writable RAM with registered, write-first read data.
module dmem_bram #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  localparam int   IW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [IW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_reg;
  logic [31:0] merged;

  // Written lanes bypass to the read port so a store returns its own new data.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged[gi*8 +: 8] = we[gi] ? wdata[gi*8 +: 8] : mem[addr][gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
      rdata_reg <= merged;
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store data memory controller: sized accesses, extension, optional
// two-cycle split for word-crossing misaligned accesses.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS      = 1024,
  parameter bit    ALLOW_MISALIGNED = 1'b1,
  parameter string INIT_FILE        = "",
  localparam int   IW               = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_memop,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  state_e        state_reg;
  logic          pend_valid_reg, pend_fault_reg, pend_load_reg, pend_split_reg, pend_uns_reg;
  logic [1:0]    pend_off_reg;
  logic [2:0]    pend_size_reg;
  logic [IW-1:0] split_idx_reg;
  logic [3:0]    split_we_reg;
  logic [31:0]   split_wdata_reg, lo_word_reg, rdata_hold_reg;
  logic          fault_hold_reg;

  logic          accept, fault, crossing, misaligned, bad_op;
  logic [1:0]    off, amask;
  logic [2:0]    size;
  logic [IW-1:0] idx;
  logic [7:0]    be;
  logic [63:0]   wdata_shift, load_window;
  logic [31:0]   load_aligned, resp_data_now;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [IW-1:0] ram_addr;
  logic [31:0]   ram_wdata, ram_rdata;

  assign req_ready   = (state_reg == IDLE);
  assign accept      = req_valid && req_ready;
  assign off         = req_addr[1:0];
  assign idx         = req_addr[IW+1:2];
  assign size        = size_of(req_memop[1:0]);
  assign be          = byte_en(off, size);
  assign wdata_shift = {32'b0, req_wdata} << {off, 3'b000};
  assign amask       = size[2] ? 2'b11 : (size[1] ? 2'b01 : 2'b00);
  assign misaligned  = |(off & amask);
  assign crossing    = ({2'b00, off} + {1'b0, size}) > 4'd4;
  assign bad_op      = !(req_memop inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});

  // A crossing access at the last word would need word 0; that wrap is refused.
  assign fault = bad_op || (req_we && req_memop[2]) || (|req_addr[31:IW+2])
              || (crossing && (idx == {IW{1'b1}}))
              || (misaligned && !ALLOW_MISALIGNED);

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0;
    ram_addr  = idx;
    ram_wdata = wdata_shift[31:0];
    if (state_reg == SPLIT) begin
      ram_en    = 1'b1;
      ram_addr  = split_idx_reg;
      ram_we    = split_we_reg;
      ram_wdata = split_wdata_reg;
    end else if (accept && !fault) begin
      ram_en = 1'b1;
      ram_we = req_we ? be[3:0] : 4'b0;
    end
  end

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .INIT_FILE  (INIT_FILE)
  ) u_bram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  assign load_window   = pend_split_reg ? {ram_rdata, lo_word_reg} : {32'b0, ram_rdata};
  assign load_aligned  = 32'(load_window >> {pend_off_reg, 3'b000});
  assign resp_data_now = pend_load_reg ? extend(load_aligned, pend_size_reg, pend_uns_reg) : 32'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pend_valid_reg  <= 1'b0;
      pend_fault_reg  <= 1'b0;
      pend_load_reg   <= 1'b0;
      pend_split_reg  <= 1'b0;
      pend_uns_reg    <= 1'b0;
      pend_off_reg    <= 2'b0;
      pend_size_reg   <= 3'd4;
      split_idx_reg   <= '0;
      split_we_reg    <= 4'b0;
      split_wdata_reg <= 32'b0;
      lo_word_reg     <= 32'b0;
      rdata_hold_reg  <= 32'b0;
      fault_hold_reg  <= 1'b0;
    end else begin
      pend_valid_reg <= 1'b0;
      if (pend_valid_reg) begin
        rdata_hold_reg <= resp_data_now;
        fault_hold_reg <= pend_fault_reg;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            pend_fault_reg  <= fault;
            pend_load_reg   <= !req_we && !fault;
            pend_off_reg    <= off;
            pend_size_reg   <= size;
            pend_uns_reg    <= req_memop[2];
            split_idx_reg   <= idx + IW'(1);
            split_we_reg    <= req_we ? be[7:4] : 4'b0;
            split_wdata_reg <= wdata_shift[63:32];
            if (!fault && crossing) begin
              state_reg      <= SPLIT;
              pend_split_reg <= 1'b1;
            end else begin
              pend_valid_reg <= 1'b1;
              pend_split_reg <= 1'b0;
            end
          end
        end
        SPLIT: begin
          lo_word_reg    <= ram_rdata;
          pend_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign resp_valid = pend_valid_reg;
  assign resp_rdata = pend_valid_reg ? resp_data_now  : rdata_hold_reg;
  assign resp_fault = pend_valid_reg ? pend_fault_reg : fault_hold_reg;

endmodule
